// File: rtl/io_input_conditioner.sv
// Input conditioner for slide switches and push buttons.
// Every raw bit runs through a two-flop synchronizer and its own debounce FSM.
// The top level derives registered press/release/change pulses and sticky
// per-key pending flags from the debounced levels.

// One lane: synchronizer, debounce FSM and the committed level.
module io_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o,
  output logic commit_o
);
  typedef enum logic {IDLE, COUNT} state_t;

  // The IDLE cycle that first sees the mismatch is already one held cycle.
  // COUNT therefore commits one count early, so the total hold is
  // DEBOUNCE_CYCLES cycles.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic             s1_q, s1_d, s2_q, s2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           state_q, state_d;

  // Synchronizer, counter, FSM and level registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      state_q  <= IDLE;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

  // Debounce next state. A revert before the count completes drops the glitch.
  always_comb begin
    s1_d     = raw_i;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    state_d  = state_q;
    commit_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (s2_q != stable_q) state_d = COUNT;
      end
      COUNT: begin
        if (s2_q == stable_q) begin
          state_d = IDLE;
        end else if (cnt_q == LAST) begin
          stable_d = s2_q;
          commit_o = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stable_o = stable_q;
endmodule

module io_input_conditioner #(
  parameter int NUM_SW          = 10,
  parameter int NUM_KEY         = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_SW-1:0]         sw_raw,
  input  logic [NUM_KEY-1:0]        key_n_raw,
  output logic [NUM_SW+NUM_KEY-1:0] io_input_bus,
  output logic [NUM_KEY-1:0]        key_press_pulse,
  output logic [NUM_KEY-1:0]        key_release_pulse,
  output logic [NUM_KEY-1:0]        key_pending,
  input  logic [NUM_KEY-1:0]        key_pending_clear,
  output logic                      sw_changed
);
  localparam int NB = NUM_SW + NUM_KEY;

  logic [NB-1:0]      raw_in, stable, commit;
  logic [NUM_KEY-1:0] key_stable, key_commit;
  logic [NUM_KEY-1:0] press_q, press_d, release_q, release_d, pending_q, pending_d;
  logic               sw_changed_q, sw_changed_d;

  // Keys are inverted ahead of the synchronizer so every lane is active-high.
  assign raw_in = {~key_n_raw, sw_raw};

  for (genvar i = 0; i < NB; i++) begin : g_lane
    io_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clock   (clock),
      .reset   (reset),
      .raw_i   (raw_in[i]),
      .stable_o(stable[i]),
      .commit_o(commit[i])
    );
  end

  assign key_stable = stable[NB-1:NUM_SW];
  assign key_commit = commit[NB-1:NUM_SW];

  // Pulses and pending flags. A commit flips the level, so the old level gives the direction.
  // The set term covers both the commit edge and the cycle the pulse is visible.
  // A clear issued against an observed pulse therefore cannot lose that press.
  always_comb begin
    press_d      = key_commit & ~key_stable;
    release_d    = key_commit & key_stable;
    sw_changed_d = |commit[NUM_SW-1:0];
    pending_d    = (pending_q & ~key_pending_clear) | press_d | press_q;
  end

  // Pulse and pending registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      press_q      <= '0;
      release_q    <= '0;
      pending_q    <= '0;
      sw_changed_q <= 1'b0;
    end else begin
      press_q      <= press_d;
      release_q    <= release_d;
      pending_q    <= pending_d;
      sw_changed_q <= sw_changed_d;
    end
  end

  assign io_input_bus      = stable;
  assign key_press_pulse   = press_q;
  assign key_release_pulse = release_q;
  assign key_pending       = pending_q;
  assign sw_changed        = sw_changed_q;
endmodule

// File: tb/tb_io_input_conditioner.sv
// Scoreboard bench for io_input_conditioner with DEBOUNCE_CYCLES = 4.
// A raw change driven after edge e is captured at edge e+1.
// Its commit is therefore expected at edge e+6.
module tb_io_input_conditioner;
  localparam int NUM_SW = 10, NUM_KEY = 4, DB = 4, CNT_W = 3;
  localparam int NB = NUM_SW + NUM_KEY;

  logic               clock = 1'b0;
  logic               reset;
  logic [NUM_SW-1:0]  sw_raw;
  logic [NUM_KEY-1:0] key_n_raw, key_pending_clear;
  logic [NB-1:0]      io_input_bus;
  logic [NUM_KEY-1:0] key_press_pulse, key_release_pulse, key_pending;
  logic               sw_changed;

  io_input_conditioner #(
    .NUM_SW(NUM_SW), .NUM_KEY(NUM_KEY), .DEBOUNCE_CYCLES(DB), .CNT_W(CNT_W)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .sw_raw           (sw_raw),
    .key_n_raw        (key_n_raw),
    .io_input_bus     (io_input_bus),
    .key_press_pulse  (key_press_pulse),
    .key_release_pulse(key_release_pulse),
    .key_pending      (key_pending),
    .key_pending_clear(key_pending_clear),
    .sw_changed       (sw_changed)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          edge_n;
    int          kind;
    logic [15:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0, n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] observe(input int kind);
    case (kind)
      0:       return 16'(io_input_bus);
      1:       return 16'(key_press_pulse);
      2:       return 16'(key_release_pulse);
      3:       return 16'(key_pending);
      4:       return 16'(sw_changed);
      default: return 16'h0;
    endcase
  endfunction

  task automatic expect_at(input int rel, input int kind, input logic [15:0] v, input string tag);
    exp_t x;
    x.edge_n = cyc + rel;
    x.kind   = kind;
    x.val    = v;
    x.tag    = tag;
    sb.push_back(x);
  endtask

  task automatic exp_all(input int rel, input logic [15:0] bus, input logic [3:0] pr,
                         input logic [3:0] rl, input logic [3:0] pd, input logic sc,
                         input string tag);
    expect_at(rel, 0, bus, {tag, ".bus"});
    expect_at(rel, 1, 16'(pr), {tag, ".press"});
    expect_at(rel, 2, 16'(rl), {tag, ".release"});
    expect_at(rel, 3, 16'(pd), {tag, ".pending"});
    expect_at(rel, 4, 16'(sc), {tag, ".sw_changed"});
  endtask

  // One rising edge, then compare every expectation due at that edge.
  task automatic tick();
    exp_t keep[$];
    @(posedge clock);
    cyc++;
    #1;
    foreach (sb[i]) begin
      if (sb[i].edge_n == cyc)
        chk($sformatf("%s@%0d", sb[i].tag, sb[i].edge_n), observe(sb[i].kind), sb[i].val);
      else
        keep.push_back(sb[i]);
    end
    sb = keep;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1; sw_raw = '1; key_n_raw = '0; key_pending_clear = '0;

    // Reset state with every switch on and every key pressed.
    for (int i = 0; i < 3; i++) begin
      exp_all(1, 16'h0, 4'h0, 4'h0, 4'h0, 1'b0, "in_reset");
      tick();
    end
    reset = 1'b0;
    exp_all(1, 16'h0, 4'h0, 4'h0, 4'h0, 1'b0, "rst_cap");
    exp_all(5, 16'h0, 4'h0, 4'h0, 4'h0, 1'b0, "rst_pre");
    exp_all(6, 16'h3FFF, 4'hF, 4'h0, 4'hF, 1'b1, "rst_commit");
    exp_all(7, 16'h3FFF, 4'h0, 4'h0, 4'hF, 1'b0, "rst_post");
    run(7);
    key_pending_clear = '1;
    expect_at(1, 3, 16'h0, "clr_all");
    tick();
    key_pending_clear = '0;

    // Return to idle inputs through a short reset.
    sw_raw = '0; key_n_raw = '1; reset = 1'b1;
    exp_all(1, 16'h0, 4'h0, 4'h0, 4'h0, 1'b0, "idle_rst");
    tick();
    reset = 1'b0;
    exp_all(3, 16'h0, 4'h0, 4'h0, 4'h0, 1'b0, "idle");
    run(3);

    // Clean press of KEY0.
    key_n_raw[0] = 1'b0;
    exp_all(5, 16'h0, 4'h0, 4'h0, 4'h0, 1'b0, "press_pre");
    exp_all(6, 16'h0400, 4'h1, 4'h0, 4'h1, 1'b0, "press");
    exp_all(7, 16'h0400, 4'h0, 4'h0, 4'h1, 1'b0, "press_post");
    exp_all(8, 16'h0400, 4'h0, 4'h0, 4'h1, 1'b0, "press_hold");
    run(8);

    // A three-cycle glitch on SW3 is rejected.
    sw_raw[3] = 1'b1;
    for (int r = 1; r <= 8; r++) begin
      expect_at(r, 0, 16'h0400, "glitch.bus");
      expect_at(r, 4, 16'h0, "glitch.sw_changed");
    end
    run(3);
    sw_raw[3] = 1'b0;
    run(6);

    // A four-cycle pulse commits high, then the drop back commits low.
    sw_raw[3] = 1'b1;
    expect_at(5, 0, 16'h0400, "sw3_pre.bus");
    expect_at(5, 4, 16'h0, "sw3_pre.sw_changed");
    expect_at(6, 0, 16'h0408, "sw3_up.bus");
    expect_at(6, 4, 16'h1, "sw3_up.sw_changed");
    expect_at(7, 4, 16'h0, "sw3_up_post.sw_changed");
    expect_at(10, 0, 16'h0400, "sw3_down.bus");
    expect_at(10, 4, 16'h1, "sw3_down.sw_changed");
    expect_at(11, 4, 16'h0, "sw3_down_post.sw_changed");
    run(4);
    sw_raw[3] = 1'b0;
    run(8);

    // A clear of KEY1 in the pulse cycle loses to the set; the next cycle's clear wins.
    // A clear of KEY2, which has no flag set, has no effect.
    key_n_raw[1] = 1'b0;
    exp_all(6, 16'h0C00, 4'h2, 4'h0, 4'h3, 1'b0, "key1_press");
    run(6);
    key_pending_clear = 4'b0110;
    expect_at(1, 3, 16'h3, "collide.pending");
    expect_at(1, 1, 16'h0, "collide.press");
    tick();
    expect_at(1, 3, 16'h1, "clear.pending");
    tick();
    key_pending_clear = '0;
    expect_at(1, 3, 16'h1, "cleared.pending");
    tick();

    // KEY2 is pressed, then released together with SW0 and SW9.
    key_n_raw[2] = 1'b0;
    exp_all(6, 16'h1C00, 4'h4, 4'h0, 4'h5, 1'b0, "key2_press");
    run(7);
    key_n_raw[2] = 1'b1; sw_raw[0] = 1'b1; sw_raw[9] = 1'b1;
    exp_all(5, 16'h1C00, 4'h0, 4'h0, 4'h5, 1'b0, "simul_pre");
    exp_all(6, 16'h0E01, 4'h0, 4'h4, 4'h5, 1'b1, "simul");
    exp_all(7, 16'h0E01, 4'h0, 4'h0, 4'h5, 1'b0, "simul_post");
    run(8);

    // Reset lands while the SW5 count is at 2.
    sw_raw[5] = 1'b1;
    expect_at(5, 0, 16'h0E01, "mid_pre.bus");
    expect_at(5, 4, 16'h0, "mid_pre.sw_changed");
    run(5);
    reset = 1'b1;
    exp_all(1, 16'h0, 4'h0, 4'h0, 4'h0, 1'b0, "mid_rst");
    tick();
    exp_all(1, 16'h0, 4'h0, 4'h0, 4'h0, 1'b0, "mid_rst2");
    tick();
    reset = 1'b0;
    for (int r = 1; r <= 5; r++) begin
      expect_at(r, 0, 16'h0, "mid_wait.bus");
      expect_at(r, 4, 16'h0, "mid_wait.sw_changed");
    end
    exp_all(6, 16'h0E21, 4'h3, 4'h0, 4'h3, 1'b1, "mid_commit");
    exp_all(7, 16'h0E21, 4'h0, 4'h0, 4'h3, 1'b0, "mid_post");
    run(8);

    chk("leftover", 16'(sb.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
